uart_tx_arbiter: RTL

- Shares one UART transmitter between NUM_REQ byte sources using round-robin arbitration.
- Sits between requester blocks (command responders, status reporters) and the UART_TX serializer at 115200 baud (217 clks/bit at 25 MHz).
- Sequences each byte into the TX: launch pulse, wait for done, re-arbitrate.
- Adds a completion watchdog so a stalled TX cannot hang the channel.

---
 rtl/uart_tx_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX serializer among NUM_REQ byte sources,
// with a completion watchdog. Optional burst lock: define UART_ARB_BURST_LOCK_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int TIMEOUT_CLKS = 2604
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic [NUM_REQ-1:0]   i_Req_DV,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  input  logic [NUM_REQ-1:0]   i_Req_Last,
  output logic [NUM_REQ-1:0]   o_Req_Ack,
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic                 o_TX_DV,
  output logic [7:0]           o_TX_Byte,
  input  logic                 i_TX_Active,
  input  logic                 i_TX_Done,
  output logic                 o_Busy,
  output logic                 o_Timeout
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CLKS);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT_DONE = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 tx_dv_q, tx_dv_d;
  logic [7:0]           byte_q, byte_d;
  logic                 timeout_q, timeout_d;
  logic                 lock_q, lock_d;

  logic [7:0]           req_bytes [NUM_REQ];
  logic [IW-1:0]        rr_idx, sel_idx, cand;
  logic                 rr_found, sel_ok;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_bytes[g] = i_Req_Byte[8*g +: 8];
  end

  // Round-robin search upward from the last grant, wrapping to requester 0.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    cand     = ptr_q;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (int'(ptr_q) + i >= NUM_REQ) begin
        cand = IW'(int'(ptr_q) + i - NUM_REQ);
      end else begin
        cand = IW'(int'(ptr_q) + i);
      end
      if (!rr_found && i_Req_DV[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end else begin
        rr_found = rr_found;
      end
    end
  end

`ifdef UART_ARB_BURST_LOCK_EN
  // A locked burst owner is the only legal launcher; others wait.
  always_comb begin
    if (lock_q) begin
      sel_ok  = i_Req_DV[ptr_q];
      sel_idx = ptr_q;
    end else begin
      sel_ok  = rr_found;
      sel_idx = rr_idx;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^{i_Req_Last, lock_q};
  assign sel_ok      = rr_found;
  assign sel_idx     = rr_idx;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    ack_d     = '0;
    tx_dv_d   = 1'b0;
    byte_d    = byte_q;
    timeout_d = 1'b0;
    lock_d    = lock_q;
    case (state_q)
      IDLE: begin
        if (sel_ok && !i_TX_Active) begin
          state_d = WAIT_DONE;
          tx_dv_d = 1'b1;
          ack_d   = NUM_REQ'(1) << sel_idx;
          grant_d = NUM_REQ'(1) << sel_idx;
          byte_d  = req_bytes[sel_idx];
          ptr_d   = sel_idx;
          cnt_d   = '0;
`ifdef UART_ARB_BURST_LOCK_EN
          lock_d  = !i_Req_Last[sel_idx];
`else
          lock_d  = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        cnt_d = cnt_q + CW'(1);
        // Done takes priority over a coincident watchdog expiry.
        if (i_TX_Done) begin
          state_d = IDLE;
          grant_d = lock_q ? grant_q : '0;
        end else if (cnt_q == CW'(TIMEOUT_CLKS - 1)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
          grant_d   = '0;
          lock_d    = 1'b0;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        lock_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; pointer resets so requester 0 is first.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= IDLE;
      ptr_q     <= IW'(NUM_REQ - 1);
      cnt_q     <= '0;
      grant_q   <= '0;
      ack_q     <= '0;
      tx_dv_q   <= 1'b0;
      byte_q    <= 8'h00;
      timeout_q <= 1'b0;
      lock_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      tx_dv_q   <= tx_dv_d;
      byte_q    <= byte_d;
      timeout_q <= timeout_d;
      lock_q    <= lock_d;
    end
  end

  assign o_Req_Ack = ack_q;
  assign o_Grant   = grant_q;
  assign o_TX_DV   = tx_dv_q;
  assign o_TX_Byte = byte_q;
  assign o_Timeout = timeout_q;
  assign o_Busy    = (state_q != IDLE);

endmodule
